// File: rtl/tank_sprite_scheduler.sv
// Two-tank scanline sprite scheduler: per-line hit check, hblank row fetch into shadow buffers,
// swap on line_start, registered pixel lookup. Define SPRITE_FLIP_EN to add per-tank flip.
module tank_sprite_scheduler #(
    parameter int unsigned SPR_H    = 25,
    parameter int unsigned SPR_W    = 18,
    parameter int unsigned PIX_BITS = 6,
    parameter int unsigned COORD_W  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [COORD_W-1:0]        next_y,
    input  logic [COORD_W-1:0]        tank0_x,
    input  logic [COORD_W-1:0]        tank0_y,
    input  logic [COORD_W-1:0]        tank1_x,
    input  logic [COORD_W-1:0]        tank1_y,
    input  logic [1:0]                tank_en,
`ifdef SPRITE_FLIP_EN
    input  logic [1:0]                tank_flip,
`endif
    output logic                      rom_req,
    output logic                      rom_sel,
    output logic [4:0]                rom_row,
    input  logic                      rom_ack,
    input  logic [SPR_W*PIX_BITS-1:0] rom_data,
    input  logic [COORD_W-1:0]        draw_x,
    output logic                      pix_valid,
    output logic [PIX_BITS-1:0]       pix_index,
    output logic                      pix_owner,
    output logic                      overrun
);
    localparam int unsigned RowW = SPR_W * PIX_BITS;

    typedef enum logic [2:0] {StIdle, StCheck, StFetchA, StFetchB, StDone} state_e;
    state_e state_q, state_d;

    logic [COORD_W-1:0]          ny_q, ny_d;
    logic [1:0][COORD_W-1:0]     tx_q, tx_d, ty_q, ty_d;
    logic [1:0]                  en_q, en_d;
    logic                        first_q, first_d;
    logic [1:0][RowW-1:0]        shadow_q, shadow_d, active_q, active_d;
    logic [1:0]                  shadow_v_q, shadow_v_d, active_v_q, active_v_d;
    logic                        overrun_q, overrun_d;
    logic                        pix_valid_q, pix_valid_d, pix_owner_q, pix_owner_d;
    logic [PIX_BITS-1:0]         pix_index_q, pix_index_d;
    logic [1:0]                  flip_row, flip_pix;
    logic [1:0][COORD_W-1:0]     dy, dx;
    logic [1:0]                  hit, opaque;
    logic [1:0][4:0]             row;
    logic [1:0][PIX_BITS-1:0]    pix;
    logic                        swap, abort, serve;
    int unsigned                 slot;

`ifdef SPRITE_FLIP_EN
    logic [1:0] flip_q, flip_d, act_flip_q, act_flip_d;
    assign flip_row = flip_q;
    assign flip_pix = act_flip_q;
`else
    assign flip_row = '0;
    assign flip_pix = '0;
`endif

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            dy[t]  = ny_q - ty_q[t];
            hit[t] = en_q[t] && (dy[t] < COORD_W'(SPR_H));
            row[t] = flip_row[t] ? 5'(SPR_H - 1) - dy[t][4:0] : dy[t][4:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // A line_start before fetches finish restarts the check with the new line.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (line_start) state_d = StCheck;
            StCheck: begin
                if (line_start)         state_d = StCheck;
                else if (hit[first_q])  state_d = StFetchA;
                else if (hit[~first_q]) state_d = StFetchB;
                else                    state_d = StDone;
            end
            StFetchA: begin
                if (line_start)   state_d = StCheck;
                else if (rom_ack) state_d = hit[~first_q] ? StFetchB : StDone;
            end
            StFetchB: begin
                if (line_start)   state_d = StCheck;
                else if (rom_ack) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rom_req = 1'b0;
        serve   = first_q;
        unique case (state_q)
            StFetchA: begin rom_req = 1'b1; serve = first_q;  end
            StFetchB: begin rom_req = 1'b1; serve = ~first_q; end
            default: ;
        endcase
        rom_sel = rom_req & serve;
        rom_row = rom_req ? row[serve] : '0;
    end

    always_comb begin
        ny_d       = ny_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        en_d       = en_q;
        first_d    = first_q;
        shadow_d   = shadow_q;
        shadow_v_d = shadow_v_q;
        active_d   = active_q;
        active_v_d = active_v_q;
        overrun_d  = overrun_q;
`ifdef SPRITE_FLIP_EN
        flip_d     = flip_q;
        act_flip_d = act_flip_q;
`endif
        swap  = line_start && (state_q == StIdle || state_q == StDone);
        abort = line_start && !swap;
        if (line_start) begin
            ny_d = next_y;
            tx_d = {tank1_x, tank0_x};
            ty_d = {tank1_y, tank0_y};
            en_d = tank_en;
`ifdef SPRITE_FLIP_EN
            flip_d = tank_flip;
`endif
        end
        if (swap) begin
            first_d    = ~first_q;
            active_d   = shadow_q;
            active_v_d = shadow_v_q;
`ifdef SPRITE_FLIP_EN
            act_flip_d = flip_q;
`endif
        end
        if (abort) begin
            active_v_d = '0;
            overrun_d  = 1'b1;
        end
        if (state_q == StCheck) shadow_v_d = '0;
        if (rom_req && rom_ack && !line_start) begin
            shadow_d[serve]   = rom_data;
            shadow_v_d[serve] = 1'b1;
        end
    end

    // Pixel 0 sits in the row MSBs; tank 0 wins on overlap.
    always_comb begin
        slot = 0;
        for (int t = 0; t < 2; t++) begin
            dx[t]     = draw_x - tx_q[t];
            pix[t]    = '0;
            opaque[t] = 1'b0;
            if (active_v_q[t] && (dx[t] < COORD_W'(SPR_W))) begin
                slot      = flip_pix[t] ? 32'(dx[t]) : SPR_W - 1 - 32'(dx[t]);
                pix[t]    = active_q[t][slot*PIX_BITS +: PIX_BITS];
                opaque[t] = (pix[t] != '0);
            end
        end
        pix_valid_d = |opaque;
        pix_owner_d = ~opaque[0] & opaque[1];
        pix_index_d = opaque[0] ? pix[0] : (opaque[1] ? pix[1] : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ny_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            en_q        <= '0;
            first_q     <= 1'b0;
            shadow_q    <= '0;
            shadow_v_q  <= '0;
            active_q    <= '0;
            active_v_q  <= '0;
            overrun_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
            pix_owner_q <= 1'b0;
`ifdef SPRITE_FLIP_EN
            flip_q      <= '0;
            act_flip_q  <= '0;
`endif
        end else begin
            ny_q        <= ny_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            en_q        <= en_d;
            first_q     <= first_d;
            shadow_q    <= shadow_d;
            shadow_v_q  <= shadow_v_d;
            active_q    <= active_d;
            active_v_q  <= active_v_d;
            overrun_q   <= overrun_d;
            pix_valid_q <= pix_valid_d;
            pix_index_q <= pix_index_d;
            pix_owner_q <= pix_owner_d;
`ifdef SPRITE_FLIP_EN
            flip_q      <= flip_d;
            act_flip_q  <= act_flip_d;
`endif
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_index = pix_index_q;
    assign pix_owner = pix_owner_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Bench for tank_sprite_scheduler: directed line sequences plus random lines, checked against a
// line-level model (hit rules, round-robin order, per-pixel arrays). Honours SPRITE_FLIP_EN.
module tb_tank_sprite_scheduler;
    logic         clk = 1'b0;
    logic         reset;
    logic         line_start;
    logic [9:0]   next_y, tank0_x, tank0_y, tank1_x, tank1_y, draw_x;
    logic [1:0]   tank_en;
    logic         rom_req, rom_sel, rom_ack;
    logic [4:0]   rom_row;
    logic [107:0] rom_data;
    logic         pix_valid, pix_owner, overrun;
    logic [5:0]   pix_index;
`ifdef SPRITE_FLIP_EN
    logic [1:0]   tank_flip;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Stimulus coordinates and reference-model state
    int       tx[2], ty[2];
    bit [1:0] tflip;
    bit       fs, busy, exp_ovr, overlap_mode;
    bit [1:0] sv, av, len, lflip, aflip;
    int       lx[2], lty[2], cur_ny;
    int       sh_px[2][18];
    int       act_px[2][18];

    assign tank0_x = 10'(tx[0]);
    assign tank1_x = 10'(tx[1]);
    assign tank0_y = 10'(ty[0]);
    assign tank1_y = 10'(ty[1]);
`ifdef SPRITE_FLIP_EN
    assign tank_flip = tflip;
`endif

    always #5 clk = ~clk;

    tank_sprite_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .line_start(line_start),
        .next_y    (next_y),
        .tank0_x   (tank0_x),
        .tank0_y   (tank0_y),
        .tank1_x   (tank1_x),
        .tank1_y   (tank1_y),
        .tank_en   (tank_en),
`ifdef SPRITE_FLIP_EN
        .tank_flip (tank_flip),
`endif
        .rom_req   (rom_req),
        .rom_sel   (rom_sel),
        .rom_row   (rom_row),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .draw_x    (draw_x),
        .pix_valid (pix_valid),
        .pix_index (pix_index),
        .pix_owner (pix_owner),
        .overrun   (overrun)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [107:0] pack(input int px[18]);
        logic [107:0] r;
        r = '0;
        for (int i = 0; i < 18; i++) r[(17 - i)*6 +: 6] = 6'(px[i]);
        return r;
    endfunction

    task automatic model_reset();
        fs = 0; busy = 0; exp_ovr = 0;
        sv = 2'b00; av = 2'b00; lflip = 2'b00; aflip = 2'b00;
    endtask

    // Pulse line_start; optionally drive an ack in the same cycle (must be ignored).
    task automatic start_line(input int ny, input bit ack_too);
        next_y = 10'(ny);
        line_start = 1'b1;
        if (ack_too) begin rom_ack = 1'b1; rom_data = '1; end
        tick;
        line_start = 1'b0;
        rom_ack = 1'b0;
        if (!busy) begin
            act_px = sh_px; av = sv; aflip = lflip; fs = !fs;
        end else begin
            av = 2'b00; exp_ovr = 1;
        end
        sv = 2'b00; lx = tx; lty = ty; len = tank_en; lflip = tflip; cur_ny = ny; busy = 1;
    endtask

    task automatic fetch_one(input bit sel, input int row, input int dly_in);
        int px[18];
        int dly;
        dly = (dly_in < 0) ? int'($urandom_range(0, 3)) : dly_in;
        chk("req", rom_req, 1);
        chk("sel", rom_sel, sel);
        chk("row", rom_row, row);
        for (int i = 0; i < dly; i++) begin
            tick;
            chk("req_hold", rom_req, 1);
            chk("sel_hold", rom_sel, sel);
            chk("row_hold", rom_row, row);
        end
        for (int i = 0; i < 18; i++)
            px[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
        if (overlap_mode) begin
            px[3] = sel ? 9 : 0;
            px[5] = sel ? 11 : 7;
        end
        rom_data = pack(px);
        rom_ack = 1'b1;
        tick;
        rom_ack = 1'b0;
        rom_data = {4{27'h5a5a5a5}};
        sh_px[sel] = px;
        sv[sel] = 1'b1;
    endtask

    // Called once the FSM has left CHECK: serve hits in round-robin order.
    task automatic fetch_hits(input int dly);
        int dy[2];
        int rw[2];
        bit [1:0] hit;
        for (int t = 0; t < 2; t++) begin
            dy[t]  = (cur_ny - lty[t] + 1024) % 1024;
            hit[t] = len[t] && (dy[t] < 25);
            rw[t]  = lflip[t] ? 24 - dy[t] : dy[t];
        end
        if (hit[fs])  fetch_one(fs, rw[fs], dly);
        if (hit[!fs]) fetch_one(!fs, rw[!fs], dly);
        chk("req_done", rom_req, 0);
        chk("overrun", overrun, exp_ovr);
        busy = 0;
    endtask

    task automatic pix_chk(input int x);
        bit ev, eo;
        int ei, dx, p;
        draw_x = 10'(x);
        tick;
        ev = 0; ei = 0; eo = 0;
        for (int t = 1; t >= 0; t--) begin
            dx = (x - lx[t] + 1024) % 1024;
            if (av[t] && dx < 18) begin
                p = act_px[t][aflip[t] ? 17 - dx : dx];
                if (p != 0) begin ev = 1; ei = p; eo = (t == 1); end
            end
        end
        chk("pix_valid", pix_valid, ev);
        chk("pix_index", pix_index, ei);
        chk("pix_owner", pix_owner, eo);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; next_y = '0; draw_x = '0;
        rom_ack = 1'b0; rom_data = '0; tank_en = 2'b00; tflip = 2'b00; overlap_mode = 0;
        tx = '{0, 0}; ty = '{0, 0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_req", rom_req, 0);
        chk("rst_sel", rom_sel, 0);
        chk("rst_row", rom_row, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_index", pix_index, 0);
        chk("rst_pix_owner", pix_owner, 0);
        chk("rst_overrun", overrun, 0);

        // Single tank on the line, ack after 3 cycles, then pixel readback
        tx = '{100, 300}; ty = '{50, 400}; tank_en = 2'b11;
        start_line(52, 0); tick; fetch_hits(3);
        tick; chk("one_req_only", rom_req, 0);
        start_line(53, 0); tick; fetch_hits(-1);
        for (int k = -1; k <= 18; k++) pix_chk(100 + k);

        // Both tanks hit on consecutive lines: order alternates
        tx = '{100, 200}; ty = '{50, 45};
        for (int ln = 54; ln < 58; ln++) begin start_line(ln, 0); tick; fetch_hits(-1); end
        for (int k = 98; k <= 120; k++) pix_chk(k);
        for (int k = 198; k <= 220; k++) pix_chk(k);

        // Vertical boundaries and enable
        ty = '{50, 600};
        start_line(74, 0); tick; fetch_hits(-1);
        start_line(75, 0); tick; chk("dy25_no_req", rom_req, 0); fetch_hits(-1);
        start_line(49, 0); tick; chk("dy_wrap_no_req", rom_req, 0); fetch_hits(-1);
        tank_en = 2'b10;
        start_line(60, 0); tick; chk("en_off_no_req", rom_req, 0); fetch_hits(-1);
        tank_en = 2'b11;

        // Overlap at the same x: tank 0 priority, transparency reveals tank 1
        overlap_mode = 1;
        tx = '{200, 200}; ty = '{50, 50};
        start_line(56, 0); tick; fetch_hits(-1);
        overlap_mode = 0;
        start_line(57, 0); tick; fetch_hits(-1);
        for (int k = 199; k <= 218; k++) pix_chk(k);
        pix_chk(203);
        chk("ovl_show_t1_owner", pix_owner, 1);
        chk("ovl_show_t1_index", pix_index, 9);
        pix_chk(205);
        chk("ovl_t0_owner", pix_owner, 0);
        chk("ovl_t0_index", pix_index, 7);

        // Overrun: ack withheld, next line_start arrives with an ack in the same cycle
        tx = '{100, 300}; ty = '{50, 52};
        start_line(60, 0); tick;
        chk("ovr_req_pending", rom_req, 1);
        tick; tick;
        start_line(61, 1);
        chk("ovr_set", overrun, 1);
        chk("ovr_req_dropped", rom_req, 0);
        for (int k = 99; k <= 118; k++) pix_chk(k);
        for (int k = 299; k <= 318; k++) pix_chk(k);
        fetch_hits(-1);
        start_line(62, 0); tick; fetch_hits(-1);
        for (int k = 99; k <= 118; k++) pix_chk(k);

        // Random lines
        for (int i = 0; i < 10; i++) begin
            int ny;
            ny = int'($urandom_range(30, 900));
            tx[0] = int'($urandom_range(0, 1000));
            tx[1] = int'($urandom_range(0, 1000));
            ty[0] = (ny - int'($urandom_range(0, 30)) + 1024) % 1024;
            ty[1] = (ny - int'($urandom_range(0, 30)) + 1024) % 1024;
            tank_en = 2'($urandom_range(0, 3));
            start_line(ny, 0); tick; fetch_hits(-1);
            for (int j = 0; j < 8; j++)
                pix_chk(tx[$urandom_range(0, 1)] + int'($urandom_range(0, 19)) - 1);
        end

`ifdef SPRITE_FLIP_EN
        // Flipped tank 0: dy=0 fetches the last row, dx=0 shows the last pixel
        tank_en = 2'b11; tflip = 2'b01;
        tx = '{100, 300}; ty = '{50, 600};
        start_line(50, 0); tick;
        chk("flip_row24", rom_row, 24);
        fetch_hits(-1);
        tflip = 2'b00;
        start_line(51, 0); tick; fetch_hits(-1);
        for (int k = 99; k <= 118; k++) pix_chk(k);
`endif

        // Reset in the middle of FETCH_A
        tank_en = 2'b11; tx = '{100, 100}; ty = '{50, 50};
        start_line(70, 0); tick;
        chk("pre_rst_req", rom_req, 1);
        reset = 1'b1;
        tick;
        chk("mid_rst_req", rom_req, 0);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        reset = 1'b0;
        model_reset();
        pix_chk(100);
        start_line(52, 0); tick; fetch_hits(-1);
        pix_chk(102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
